grid_mem_ctl: RTL and testbench

// - Owns the 10x10 board-state store that draw_ships scans. Its read port answers the grid_addr/grid_status lookups.
// - Game logic writes cells through a req/ack write port. A clear FSM wipes the board.
// - Keeps SHIP/HIT cell counters and raises all_sunk for end-of-game detection.

---
 rtl/grid_pkg.sv | 56 +++++
 rtl/grid_mem_ctl_if.sv | 25 ++
 rtl/grid_mem_ctl.sv | 141 ++++++++++++++
 tb/tb_grid_mem_ctl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// grid_pkg: cell encoding, FSM states and counter helpers shared by
// grid_mem_ctl, draw_ships and the game logic.
package grid_pkg;

    localparam int GRID_SIZE_DEF = 10;
    localparam int COORD_W_DEF   = 4;
    localparam int CNT_W_DEF     = 7;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        SHIP  = 2'd1,
        MISS  = 2'd2,
        HIT   = 2'd3
    } cell_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    typedef struct packed {
        logic ship_inc;
        logic ship_dec;
        logic hit_inc;
        logic hit_dec;
    } cnt_delta_t;

    // Row-major flat index of cell (x,y).
    function automatic int unsigned cell_idx(
        int unsigned x,
        int unsigned y,
        int unsigned size
    );
        return y * size + x;
    endfunction

    function automatic logic is_ship(cell_t c);
        return (c == SHIP) || (c == HIT);
    endfunction

    function automatic logic is_shot(cell_t c);
        return (c == MISS) || (c == HIT);
    endfunction

    // Counter movement implied by rewriting a cell from old_c to new_c.
    function automatic cnt_delta_t cnt_delta(cell_t old_c, cell_t new_c);
        cnt_delta_t d;
        d.ship_inc = !is_ship(old_c) && is_ship(new_c);
        d.ship_dec = is_ship(old_c) && !is_ship(new_c);
        d.hit_inc  = (old_c != HIT) && (new_c == HIT);
        d.hit_dec  = (old_c == HIT) && (new_c != HIT);
        return d;
    endfunction

endpackage

// File: rtl/grid_mem_ctl_if.sv
// grid_mem_ctl_if: board read port plus req/ack write port.
// rd_addr/rd_status: lookup; wr_req/wr_addr/wr_status in, wr_ack/wr_err back.
interface grid_mem_ctl_if
    import grid_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF
);
    logic [2*COORD_W-1:0] rd_addr;
    cell_t                rd_status;
    logic                 wr_req;
    logic [2*COORD_W-1:0] wr_addr;
    cell_t                wr_status;
    logic                 wr_ack;
    logic                 wr_err;

    modport master (
        output rd_addr, wr_req, wr_addr, wr_status,
        input  rd_status, wr_ack, wr_err
    );

    modport slave (
        input  rd_addr, wr_req, wr_addr, wr_status,
        output rd_status, wr_ack, wr_err
    );
endinterface

// File: rtl/grid_mem_ctl.sv
// grid_mem_ctl: flop-array board store with registered read port, req/ack
// writes, a one-cell-per-cycle clear FSM and SHIP/HIT counters.
// Ports: clk, rst (sync, active low), bus (grid_mem_ctl_if.slave),
//   clear_req in, busy out, ship_cells/hit_cells out, all_sunk out.
// Option: define GRID_SHOT_GUARD_EN to reject MISS/HIT over MISS/HIT.
module grid_mem_ctl
    import grid_pkg::*;
#(
    parameter int GRID_SIZE = GRID_SIZE_DEF,
    parameter int COORD_W   = COORD_W_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    grid_mem_ctl_if.slave    bus,
    input  logic             clear_req,
    output logic             busy,
    output logic [CNT_W-1:0] ship_cells,
    output logic [CNT_W-1:0] hit_cells,
    output logic             all_sunk
);

    localparam int NCELL = GRID_SIZE * GRID_SIZE;
    localparam int IDX_W = $clog2(NCELL);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NCELL - 1);
    localparam logic [COORD_W-1:0] LIM = COORD_W'(GRID_SIZE);

    cell_t            cells [NCELL];
    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] idx;
    cell_t            old_q;

    logic [COORD_W-1:0] rd_x, rd_y, wr_x, wr_y;
    logic               rd_in, wr_in;
    logic [IDX_W-1:0]   rd_i, wr_i;
    logic               guard;
    logic               reject;
    cnt_delta_t         d;

    assign rd_x  = bus.rd_addr[2*COORD_W-1:COORD_W];
    assign rd_y  = bus.rd_addr[COORD_W-1:0];
    assign wr_x  = bus.wr_addr[2*COORD_W-1:COORD_W];
    assign wr_y  = bus.wr_addr[COORD_W-1:0];
    assign rd_in = (rd_x < LIM) && (rd_y < LIM);
    assign wr_in = (wr_x < LIM) && (wr_y < LIM);
    assign rd_i  = IDX_W'(cell_idx(32'(rd_x), 32'(rd_y), GRID_SIZE));
    assign wr_i  = IDX_W'(cell_idx(32'(wr_x), 32'(wr_y), GRID_SIZE));

`ifdef GRID_SHOT_GUARD_EN
    assign guard = is_shot(bus.wr_status) && is_shot(old_q);
`else
    assign guard = 1'b0;
`endif

    assign reject = !wr_in || guard;
    assign d      = cnt_delta(old_q, bus.wr_status);

    // While wr_ack is high the requester still holds wr_req for the
    // finished write, so IDLE must not take it a second time.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        unique case (state)
            IDLE: begin
                if (clear_req) begin
                    state_nx = CLEAR;
                end else if (bus.wr_req && !bus.wr_ack) begin
                    state_nx = WRITE;
                end
            end
            WRITE: state_nx = IDLE;
            CLEAR: begin
                busy = 1'b1;
                if (idx == LAST) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            idx           <= '0;
            old_q         <= EMPTY;
            bus.rd_status <= EMPTY;
            bus.wr_ack    <= 1'b0;
            bus.wr_err    <= 1'b0;
            ship_cells    <= '0;
            hit_cells     <= '0;
            all_sunk      <= 1'b0;
            for (int i = 0; i < NCELL; i++) begin
                cells[i] <= EMPTY;
            end
        end else begin
            state         <= state_nx;
            bus.wr_ack    <= 1'b0;
            bus.wr_err    <= 1'b0;
            bus.rd_status <= rd_in ? cells[rd_i] : EMPTY;
            all_sunk      <= (ship_cells != '0) &&
                             (hit_cells == ship_cells);
            unique case (state)
                IDLE: begin
                    idx <= '0;
                    if (state_nx == WRITE) begin
                        old_q <= wr_in ? cells[wr_i] : EMPTY;
                    end
                end
                WRITE: begin
                    bus.wr_ack <= 1'b1;
                    bus.wr_err <= reject;
                    if (!reject) begin
                        cells[wr_i] <= bus.wr_status;
                        if (d.ship_inc) begin
                            ship_cells <= ship_cells + CNT_W'(1);
                        end else if (d.ship_dec) begin
                            ship_cells <= ship_cells - CNT_W'(1);
                        end
                        if (d.hit_inc) begin
                            hit_cells <= hit_cells + CNT_W'(1);
                        end else if (d.hit_dec) begin
                            hit_cells <= hit_cells - CNT_W'(1);
                        end
                    end
                end
                CLEAR: begin
                    cells[idx] <= EMPTY;
                    idx        <= idx + IDX_W'(1);
                    if (idx == LAST) begin
                        ship_cells <= '0;
                        hit_cells  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_grid_mem_ctl.sv
// tb_grid_mem_ctl: directed stimulus with a queue-based scoreboard; a
// monitor pops expectations on wr_ack, read results and busy runs.
module tb_grid_mem_ctl;
    import grid_pkg::*;

    typedef struct {
        bit err;
        int ship;
        int hit;
        bit sunk;
        int lat;
    } wr_exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear_req;
    logic       busy;
    logic [6:0] ship_cells;
    logic [6:0] hit_cells;
    logic       all_sunk;

    grid_mem_ctl_if bus ();

    grid_mem_ctl dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .clear_req (clear_req),
        .busy      (busy),
        .ship_cells(ship_cells),
        .hit_cells (hit_cells),
        .all_sunk  (all_sunk)
    );

    always #5 clk = ~clk;

    int      n_chk  = 0;
    int      n_fail = 0;
    wr_exp_t wq[$];
    cell_t   rq[$];
    int      bq[$];
    cell_t   model[10][10];
    logic    rd_issue = 1'b0;
    logic    rd_chk   = 1'b0;
    int      age      = 0;

    task automatic check(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic flag(string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event with no expectation", name);
    endtask

    always @(posedge clk) begin
        rd_chk <= rd_issue;
        if (!bus.wr_req) age <= 0;
        else if (!bus.wr_ack) age <= age + 1;
    end

    // Monitor / scoreboard
    initial begin
        wr_exp_t e;
        bit      sk_pend = 0;
        bit      sk_exp  = 0;
        int      brun    = 0;
        cell_t   r;
        forever begin
            @(negedge clk);
            if (sk_pend) begin
                check("all_sunk", int'(all_sunk), int'(sk_exp));
                sk_pend = 0;
            end
            if (bus.wr_ack) begin
                if (wq.size() == 0) begin
                    flag("wr_ack");
                end else begin
                    e = wq.pop_front();
                    check("wr_err", int'(bus.wr_err), int'(e.err));
                    check("ship_cells", int'(ship_cells), e.ship);
                    check("hit_cells", int'(hit_cells), e.hit);
                    check("ack_latency", age, e.lat);
                    sk_pend = 1;
                    sk_exp  = e.sunk;
                end
            end
            if (rd_chk) begin
                if (rq.size() == 0) begin
                    flag("rd_status");
                end else begin
                    r = rq.pop_front();
                    check("rd_status", int'(bus.rd_status), int'(r));
                end
            end
            if (busy) begin
                brun++;
            end else if (brun > 0) begin
                if (bq.size() == 0) flag("busy");
                else check("busy_cycles", brun, bq.pop_front());
                brun = 0;
            end
        end
    end

    function automatic cell_t mval(int x, int y);
        if (x >= 10 || y >= 10) return EMPTY;
        return model[x][y];
    endfunction

    task automatic rd(int x, int y);
        bus.rd_addr = {4'(x), 4'(y)};
        rd_issue    = 1'b1;
        rq.push_back(mval(x, y));
        @(posedge clk);
        #1;
        rd_issue = 1'b0;
    endtask

    task automatic read_all();
        for (int y = 0; y < 10; y++) begin
            for (int x = 0; x < 10; x++) begin
                rd(x, y);
            end
        end
    endtask

    task automatic clr_model();
        for (int x = 0; x < 10; x++) begin
            for (int y = 0; y < 10; y++) begin
                model[x][y] = EMPTY;
            end
        end
    endtask

    task automatic wr(int x, int y, cell_t st, bit err,
                      int s, int h, bit sk, int lat, bit clr);
        wr_exp_t e;
        bit      got = 0;
        e = '{err: err, ship: s, hit: h, sunk: sk, lat: lat};
        wq.push_back(e);
        if (clr) begin
            bq.push_back(100);
            clear_req = 1'b1;
        end
        bus.wr_addr   = {4'(x), 4'(y)};
        bus.wr_status = st;
        bus.wr_req    = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = bus.wr_ack;
        end
        if (!got) begin
            check("wr_ack_timeout", 0, 1);
            void'(wq.pop_back());
        end
        @(posedge clk);
        #1;
        bus.wr_req = 1'b0;
        @(posedge clk);
        #1;
        if (clr) clr_model();
        if (!err && x < 10 && y < 10) model[x][y] = st;
    endtask

    initial begin
        rst           = 1'b0;
        clear_req     = 1'b0;
        bus.wr_req    = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_status = EMPTY;
        bus.rd_addr   = '0;
        clr_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_ship", int'(ship_cells), 0);
        check("reset_hit", int'(hit_cells), 0);
        check("reset_sunk", int'(all_sunk), 0);
        check("reset_ack", int'(bus.wr_ack), 0);
        check("reset_err", int'(bus.wr_err), 0);
        check("reset_rd", int'(bus.rd_status), 0);
        @(posedge clk);
        #1;
        read_all();
        rd(12, 3);

        wr(3, 4, SHIP, 0, 1, 0, 0, 2, 0);
        rd(3, 4);
        wr(3, 4, EMPTY, 0, 0, 0, 0, 2, 0);
        wr(0, 0, SHIP, 0, 1, 0, 0, 2, 0);
        wr(9, 9, SHIP, 0, 2, 0, 0, 2, 0);
        wr(0, 0, HIT, 0, 2, 1, 0, 2, 0);
        wr(9, 9, HIT, 0, 2, 2, 1, 2, 0);
        rd(0, 0);
        rd(9, 9);
        rd(3, 4);
        wr(10, 2, SHIP, 1, 2, 2, 1, 2, 0);
        wr(2, 12, HIT, 1, 2, 2, 1, 2, 0);
        rd(10, 2);
`ifdef GRID_SHOT_GUARD_EN
        wr(9, 9, MISS, 1, 2, 2, 1, 2, 0);
        rd(9, 9);
        wr(5, 5, HIT, 0, 3, 3, 1, 2, 0);
`else
        wr(9, 9, MISS, 0, 1, 1, 1, 2, 0);
        rd(9, 9);
        wr(5, 5, HIT, 0, 2, 2, 1, 2, 0);
`endif
        rd(5, 5);

        wr(2, 7, SHIP, 0, 1, 0, 0, 103, 1);
        read_all();

        wr(1, 1, SHIP, 0, 2, 0, 0, 2, 0);
        wr(1, 2, HIT, 0, 3, 1, 0, 2, 0);
        rd(1, 2);

        clear_req = 1'b1;
        bq.push_back(51);
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        clr_model();
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_ship", int'(ship_cells), 0);
        check("abort_hit", int'(hit_cells), 0);
        check("abort_ack", int'(bus.wr_ack), 0);
        check("abort_sunk", int'(all_sunk), 0);
        @(posedge clk);
        #1;
        read_all();

        repeat (4) @(posedge clk);
        check("wr_queue_left", wq.size(), 0);
        check("rd_queue_left", rq.size(), 0);
        check("busy_queue_left", bq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
